// File: rtl/shadow_stack_ctrl_pkg.sv
// rtl/shadow_stack_ctrl_pkg.sv - shared widths, command/LSU op types, exception record and cause codes
package shadow_stack_ctrl_pkg;

    localparam int unsigned XLEN          = 64;
    localparam int unsigned VLEN          = 39;
    localparam int unsigned TRANS_ID_BITS = 3;
    localparam int unsigned SS_SLOT_BYTES = 8;

    localparam logic [XLEN-1:0] SS_OVERFLOW  = 64'd24;
    localparam logic [XLEN-1:0] SS_UNDERFLOW = 64'd25;
    localparam logic [XLEN-1:0] SS_MISMATCH  = 64'd26;

    typedef enum logic {
        SS_PUSH = 1'b0,
        SS_POP  = 1'b1
    } ss_op_t;

    typedef enum logic [1:0] {
        FU_NONE   = 2'd0,
        SSPUSH_X1 = 2'd1,
        SSPOP     = 2'd2
    } fu_op_t;

    typedef struct packed {
        logic [XLEN-1:0] cause;
        logic [XLEN-1:0] tval;
        logic            valid;
    } exception_t;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ISSUE    = 3'd1,
        S_WAIT_RSP = 3'd2,
        S_RESP     = 3'd3,
        S_DRAIN    = 3'd4
    } ss_state_t;

    // Exceptions raised by the controller itself carry no tval.
    function automatic exception_t ss_exception(input logic [XLEN-1:0] cause);
        exception_t ex;
        ex.cause = cause;
        ex.tval  = '0;
        ex.valid = 1'b1;
        return ex;
    endfunction

endpackage

// File: rtl/shadow_stack_ctrl.sv
// rtl/shadow_stack_ctrl.sv - shadow-stack push/pop sequencer into the LSU port; bounds checks enabled by SS_BOUNDS_CHECK_EN
module shadow_stack_ctrl
    import shadow_stack_ctrl_pkg::*;
#(
    parameter int unsigned SLOT_BYTES = SS_SLOT_BYTES
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     cmd_valid_i,
    output logic                     cmd_ready_o,
    input  ss_op_t                   cmd_op_i,
    input  logic [VLEN-1:0]          cmd_data_i,
    input  logic [TRANS_ID_BITS-1:0] cmd_trans_id_i,
    output logic                     lsu_req_valid_o,
    input  logic                     lsu_req_ready_i,
    output fu_op_t                   lsu_op_o,
    output logic [VLEN-1:0]          lsu_vaddr_o,
    output logic [XLEN-1:0]          lsu_data_o,
    input  logic                     lsu_rsp_valid_i,
    input  logic [XLEN-1:0]          lsu_rsp_data_i,
    input  exception_t               lsu_rsp_ex_i,
    output logic                     res_valid_o,
    output logic [TRANS_ID_BITS-1:0] res_trans_id_o,
    output exception_t               res_ex_o,
    input  logic                     ssp_we_i,
    input  logic [VLEN-1:0]          ssp_wdata_i,
    input  logic [VLEN-1:0]          ssp_base_i,
    input  logic [VLEN-1:0]          ssp_limit_i,
    output logic [VLEN-1:0]          ssp_o,
    output logic                     busy_o
);

    localparam logic [VLEN:0] SLOT_EXT = (VLEN+1)'(SLOT_BYTES);

    ss_state_t                r_state;
    ss_state_t                w_state_nxt;
    logic [VLEN-1:0]          r_ssp;
    logic [VLEN-1:0]          r_data;
    logic [VLEN-1:0]          r_vaddr;
    ss_op_t                   r_op;
    logic [TRANS_ID_BITS-1:0] r_id;
    exception_t               r_ex;

    logic [VLEN:0]   w_push_addr_ext;
    logic [VLEN-1:0] w_ssp_inc;
    logic            w_push_ovf;
    logic            w_pop_unf;
    logic            w_bounds_fail;
    logic            w_accept;
    logic            w_rsp_fire;
    logic            w_dropped;
    logic            w_commit;
    logic            w_mismatch;
    logic            w_unused;

    // Extra top bit catches a push that would wrap below address zero.
    assign w_push_addr_ext = {1'b0, r_ssp} - SLOT_EXT;
    assign w_ssp_inc       = r_ssp + SLOT_EXT[VLEN-1:0];

`ifdef SS_BOUNDS_CHECK_EN
    logic [VLEN:0] w_pop_end_ext;
    assign w_pop_end_ext = {1'b0, r_ssp} + SLOT_EXT;
    assign w_push_ovf    = w_push_addr_ext[VLEN] || (w_push_addr_ext[VLEN-1:0] < ssp_base_i);
    assign w_pop_unf     = w_pop_end_ext > {1'b0, ssp_limit_i};
    assign w_unused      = ^lsu_rsp_data_i[XLEN-1:VLEN];
`else
    assign w_push_ovf    = 1'b0;
    assign w_pop_unf     = 1'b0;
    assign w_unused      = ^{lsu_rsp_data_i[XLEN-1:VLEN], ssp_base_i, ssp_limit_i};
`endif

    assign w_bounds_fail = (cmd_op_i == SS_PUSH) ? w_push_ovf : w_pop_unf;
    assign w_accept      = (r_state == S_IDLE) && cmd_valid_i;
    assign w_mismatch    = lsu_rsp_data_i[VLEN-1:0] != r_data;

    // A response after a flush is consumed silently; only a clean store still moves SSP.
    assign w_rsp_fire = lsu_rsp_valid_i && ((r_state == S_WAIT_RSP) || (r_state == S_DRAIN));
    assign w_dropped  = (r_state == S_DRAIN) || flush_i;
    assign w_commit   = w_rsp_fire && !lsu_rsp_ex_i.valid && (!w_dropped || (r_op == SS_PUSH));

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; a flush coinciding with the response finishes the drain on the spot.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (cmd_valid_i) begin
                    w_state_nxt = w_bounds_fail ? S_RESP : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (flush_i) begin
                    w_state_nxt = lsu_req_ready_i ? S_DRAIN : S_IDLE;
                end else if (lsu_req_ready_i) begin
                    w_state_nxt = S_WAIT_RSP;
                end
            end
            S_WAIT_RSP: begin
                if (lsu_rsp_valid_i) begin
                    w_state_nxt = flush_i ? S_IDLE : S_RESP;
                end else if (flush_i) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_RESP:  w_state_nxt = S_IDLE;
            S_DRAIN: begin
                if (lsu_rsp_valid_i) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Handshake outputs decoded from the current state.
    always_comb begin
        cmd_ready_o     = (r_state == S_IDLE);
        lsu_req_valid_o = (r_state == S_ISSUE);
        res_valid_o     = (r_state == S_RESP) && !flush_i;
        busy_o          = (r_state != S_IDLE);
    end

    // Command latch at accept and result exception capture on the response.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_op    <= SS_PUSH;
            r_data  <= '0;
            r_id    <= '0;
            r_vaddr <= '0;
            r_ex    <= '0;
        end else if (w_accept) begin
            r_op    <= cmd_op_i;
            r_data  <= cmd_data_i;
            r_id    <= cmd_trans_id_i;
            r_vaddr <= (cmd_op_i == SS_PUSH) ? w_push_addr_ext[VLEN-1:0] : r_ssp;
            if (w_bounds_fail) begin
                r_ex <= ss_exception((cmd_op_i == SS_PUSH) ? SS_OVERFLOW : SS_UNDERFLOW);
            end else begin
                r_ex <= '0;
            end
        end else if ((r_state == S_WAIT_RSP) && lsu_rsp_valid_i && !flush_i) begin
            if (lsu_rsp_ex_i.valid) begin
                r_ex <= lsu_rsp_ex_i;
            end else if ((r_op == SS_POP) && w_mismatch) begin
                r_ex <= ss_exception(SS_MISMATCH);
            end
        end
    end

    // SSP register; a CSR write overrides a commit in the same cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ssp <= '0;
        end else if (ssp_we_i) begin
            r_ssp <= ssp_wdata_i;
        end else if (w_commit) begin
            r_ssp <= (r_op == SS_PUSH) ? w_push_addr_ext[VLEN-1:0] : w_ssp_inc;
        end
    end

    assign lsu_op_o       = (r_op == SS_PUSH) ? SSPUSH_X1 : SSPOP;
    assign lsu_vaddr_o    = r_vaddr;
    assign lsu_data_o     = {{(XLEN-VLEN){1'b0}}, r_data};
    assign res_trans_id_o = r_id;
    assign res_ex_o       = r_ex;
    assign ssp_o          = r_ssp;

endmodule
